// File: rtl/common.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | common : pipeline-wide shared types (decoded control word)               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package common;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;

endpackage
`default_nettype wire

// File: rtl/ex_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_pkg : helpers shared by the EX/MEM buffer and its FIFO core       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ex_mem_pkg;

  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    ptr_inc = (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_fifo_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_fifo_core : generic circular FIFO with occupancy count and flush  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ex_mem_fifo_core
  import ex_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // No pass-through when full: readiness depends on the registered count only.
  assign push_ready = (count != CNT_BITS'(DEPTH));
  assign pop_valid  = (count != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
      end
      if (pop) begin
        rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), 32'(DEPTH)));
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is left intact on flush; only the pointers forget it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_stage_buffer : elastic EX->MEM buffer with overflow-event counter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ex_mem_stage_buffer
  import common::*;
  import ex_mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  control_type                  in_control,
  input  logic [XLEN-1:0]              in_alu_data,
  input  logic [XLEN-1:0]              in_memory_data,
  input  logic                         in_overflow_flag,
  input  logic                         in_zero_flag,
  input  logic                         in_compflg,
  input  logic [XLEN-1:0]              in_program_counter,
  output logic                         out_valid,
  input  logic                         out_ready,
  output control_type                  out_control,
  output logic [XLEN-1:0]              out_alu_data,
  output logic [XLEN-1:0]              out_memory_data,
  output logic                         out_overflow_flag,
  output logic                         out_zero_flag,
  output logic                         out_compflg,
  output logic [XLEN-1:0]              out_program_counter,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             ovf_events
);

  typedef struct packed {
    control_type     control;
    logic [XLEN-1:0] alu_data;
    logic [XLEN-1:0] memory_data;
    logic            overflow;
    logic            zero;
    logic            compflg;
    logic [XLEN-1:0] pc;
  } ex_result_t;

  localparam int ENTRY_W = $bits(ex_result_t);

  ex_result_t in_entry;
  ex_result_t head;
  logic       pop_counted;

  assign in_entry = '{
    control:     in_control,
    alu_data:    in_alu_data,
    memory_data: in_memory_data,
    overflow:    in_overflow_flag,
    zero:        in_zero_flag,
    compflg:     in_compflg,
    pc:          in_program_counter
  };

  ex_mem_fifo_core #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head),
    .count      (count)
  );

  assign out_control         = head.control;
  assign out_alu_data        = head.alu_data;
  assign out_memory_data     = head.memory_data;
  assign out_overflow_flag   = head.overflow;
  assign out_zero_flag       = head.zero;
  assign out_compflg         = head.compflg;
  assign out_program_counter = head.pc;

  // A pop coinciding with flush is discarded, so it does not count as an event.
  assign pop_counted = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_events <= '0;
    end else if (pop_counted && head.overflow && (ovf_events != '1)) begin
      ovf_events <= ovf_events + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage_buffer.md
Name: ex_mem_stage_buffer

Overview:
- Parametrised elastic buffer between the execution stage and the memory stage of the RISC-V pipeline.
- Captures the execution-stage result bundle: control, ALU result, store data, flags, compare flag and PC.
- Presents entries in order to the memory stage with a valid/ready handshake.
- Adds multi-entry depth, configurable data width, back-pressure, flush and an overflow-event counter.

Parameters:
- XLEN, 32, width of the data, ALU and PC fields.
- DEPTH, 4, number of buffered entries; power of two, ≥2.
- CNT_W, 16, width of the saturating overflow-event counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all entries (branch mispredict).
- in_valid  in  1  execution stage offers a bundle.
- in_ready  out  1  buffer can accept the bundle.
- in_control  in  control_type  decoded control word.
- in_alu_data  in  XLEN  ALU result.
- in_memory_data  in  XLEN  store data.
- in_overflow_flag  in  1  ALU overflow.
- in_zero_flag  in  1  ALU zero.
- in_compflg  in  1  compare/branch flag.
- in_program_counter  in  XLEN  PC of the instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  memory stage accepts the head entry.
- out_control, out_alu_data, out_memory_data, out_overflow_flag, out_zero_flag, out_compflg, out_program_counter  out  as the matching inputs  head entry fields.
- count  out  $clog2(DEPTH+1)  current occupancy.
- ovf_events  out  CNT_W  saturating count of popped entries with overflow_flag=1.

Behaviour:
- Reset, when rst_n=0 (asynchronous):
  - Write pointer, read pointer, count and ovf_events are 0.
  - All storage is 0, so out_valid=0 and every out_* field is 0.
  - in_ready becomes 1 in the first cycle after reset deassertion.
- Storage and pointers:
  - DEPTH-entry circular array.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push and pop:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = (count != DEPTH), combinational from registered count only. There is no pass-through when full: with count=DEPTH, in_ready=0 even if out_ready=1.
  - out_valid = (count != 0).
- Output data:
  - out_* are driven combinationally from the entry at the read pointer.
  - When count=0, out_* are forced to 0.
- Latency: a bundle pushed at edge N is visible on out_* with out_valid=1 after edge N (1-cycle latency) when the buffer was empty.
- Simultaneous push and pop (0<count<DEPTH): both pointers advance and count is unchanged.
- Push while empty with out_ready=1: the entry is stored and popped no earlier than the next cycle.
- Pop when empty is ignored. Push when full is impossible by the in_ready rule.
- Flush:
  - flush=1 at an edge sets both pointers and count to 0.
  - A concurrent push is dropped and a concurrent pop is not counted.
  - Storage contents need not be cleared.
- Ordering: strict FIFO; no reordering.
- ovf_events increments by 1 on each pop whose head has overflow_flag=1, and saturates at 2^CNT_W-1. Flush does not clear it; only reset does.
- Handshake stability: once out_valid=1, the head entry fields stay stable until popped or flushed.

Decomposition:
- Package ex_mem_pkg holds:
  - the packed struct ex_result_t (control_type, alu_data, memory_data, overflow, zero, compflg, pc), parametrised via XLEN localparam or a typedef in the module;
  - the function ptr_inc for wrap.
- control_type stays in common.
- Natural sub-module: ex_mem_fifo_core, a generic width/depth circular FIFO with count and flush. The top packs and unpacks the struct and owns ovf_events.

Test Plan:
- Reset then push a single bundle (alu_data=0x0000_00AA, pc=0x100, zero=1) with out_ready=1 → next cycle out_valid=1 with identical fields; following cycle count=0 and out_* all 0.
- With out_ready=0, push 4 bundles (alu_data=1..4) at DEPTH=4 → count=4 and in_ready=0; a 5th offer is not accepted; then out_ready=1 → pops 1,2,3,4 in order, with in_ready=1 after the first pop.
- Continuous push and pop at count=2 for 10 cycles with alu_data=incrementing → count stays 2; output sequence is exactly the input delayed; pointers wrap with no loss.
- At count=3, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, in_ready=1; the flushed and concurrent entries never appear.
- Pop 3 entries with overflow_flag=1 and 2 with 0; set CNT_W=2 and pop 5 more overflow entries → ovf_events=3, then saturates at 3; the value survives flush.
- Assert rst_n=0 mid-stream with count=2 → immediately out_valid=0, count=0, ovf_events=0, out_* all 0.
